// File: rtl/priority_arbiter_if.sv
// Request/grant bundle: requesters drive the master side, the arbiter the slave side.
interface priority_arbiter_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         mode;
  logic         done;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic         expired;

  modport master (output req, mode, done,
                  input  grant_valid, grant_idx, grant_onehot, expired);
  modport slave  (input  req, mode, done,
                  output grant_valid, grant_idx, grant_onehot, expired);
endinterface

// File: rtl/priority_arbiter.sv
// Two-state arbiter: fixed-priority or round-robin pick, held grant with optional
// tenure timeout, and a mandatory IDLE cycle between grants.
module priority_arbiter #(
  parameter int N        = 8,
  parameter int W        = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  priority_arbiter_if.slave bus
);
  localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [W:0]      N_W       = (W+1)'(N);
  localparam logic [W-1:0]    LAST_IDX  = W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q;
  logic           gv_q;
  logic           exp_q;
  logic [W-1:0]   idx_q;
  logic [W-1:0]   rr_ptr_q;
  logic [N-1:0]   oh_q;
  logic [HW-1:0]  hold_q;

  logic [W-1:0]   fp_idx_d;
  logic [W-1:0]   rr_idx_d;
  logic [W-1:0]   win_idx_d;
  logic [W-1:0]   ptr_next_d;
  logic [W:0]     rr_pos;
  logic           rel_d;
  logic           tmo_d;

  always_comb begin
    fp_idx_d = '0;
    for (int i = 0; i < N; i++)
      if (bus.req[i]) fp_idx_d = W'(i);
  end

  // Scan downward in distance from rr_ptr so the nearest requester wins last.
  always_comb begin
    rr_idx_d = '0;
    rr_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_pos = {1'b0, rr_ptr_q} + (W+1)'(k);
      if (rr_pos >= N_W) rr_pos = rr_pos - N_W;
      if (bus.req[rr_pos[W-1:0]]) rr_idx_d = rr_pos[W-1:0];
    end
  end

  assign win_idx_d  = bus.mode ? rr_idx_d : fp_idx_d;
  assign rel_d      = bus.done | ~bus.req[idx_q];
  assign tmo_d      = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);
  assign ptr_next_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gv_q     <= 1'b0;
      exp_q    <= 1'b0;
      idx_q    <= '0;
      oh_q     <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      exp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= GRANT;
            gv_q    <= 1'b1;
            idx_q   <= win_idx_d;
            oh_q    <= {{(N-1){1'b0}}, 1'b1} << win_idx_d;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          hold_q <= hold_q + 1'b1;
          // An explicit release (done or request drop) takes precedence over timeout.
          if (rel_d || tmo_d) begin
            state_q  <= IDLE;
            gv_q     <= 1'b0;
            oh_q     <= '0;
            rr_ptr_q <= ptr_next_d;
            exp_q    <= ~rel_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid  = gv_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = oh_q;
  assign bus.expired      = exp_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter (N=8, MAX_HOLD=4): each driven cycle pushes
// the expected post-edge outputs, a monitor pops and compares them after each edge.
module tb_priority_arbiter;
  logic clk;
  logic rst_n;

  priority_arbiter_if #(.N(8)) bif ();

  priority_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       gv;
    logic [2:0] idx;
    logic       ex;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h", tag, got, want);
    else n_pass++;
  endtask

  task automatic step(input string tag, input logic [7:0] req, input logic mode,
                      input logic done, input logic gv, input logic [2:0] idx,
                      input logic ex);
    exp_t e;
    @(negedge clk);
    bif.req  = req;
    bif.mode = mode;
    bif.done = done;
    e.tag = tag; e.gv = gv; e.idx = idx; e.ex = ex;
    sb.push_back(e);
  endtask

  initial begin : mon
    exp_t       e;
    logic [7:0] oh;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        oh = 8'h01;
        oh = e.gv ? (oh << e.idx) : 8'h00;
        chk({e.tag, ".gv"},  32'(bif.grant_valid),  32'(e.gv));
        chk({e.tag, ".idx"}, 32'(bif.grant_idx),    32'(e.idx));
        chk({e.tag, ".oh"},  32'(bif.grant_onehot), 32'(oh));
        chk({e.tag, ".exp"}, 32'(bif.expired),      32'(e.ex));
      end
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    bif.req = '0; bif.mode = 1'b0; bif.done = 1'b0;
    #3;
    chk("rst.gv",  32'(bif.grant_valid),  32'd0);
    chk("rst.idx", 32'(bif.grant_idx),    32'd0);
    chk("rst.oh",  32'(bif.grant_onehot), 32'd0);
    chk("rst.exp", 32'(bif.expired),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("idle", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Round-robin sweep 0..7,0 with done pulses and one IDLE sample between grants
    for (int g = 0; g < 9; g++) begin
      step($sformatf("rr%0d.g", g), 8'hFF, 1'b1, 1'b0, 1'b1, 3'(g % 8), 1'b0);
      step($sformatf("rr%0d.r", g), 8'hFF, 1'b1, 1'b1, 1'b0, 3'(g % 8), 1'b0);
    end

    // Fixed priority, hold against higher request and mode flip, then release
    step("fp.g",    8'b0101_0010, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    step("fp.hold", 8'b1101_0010, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
    step("fp.rel",  8'b1101_0010, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0);
    step("idledone", 8'h00, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0);

    // Pointer wrap from 7 to 0
    step("wrap.g7", 8'h80, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
    step("wrap.r7", 8'h80, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0);
    step("wrap.g3", 8'h88, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    step("wrap.r3", 8'h88, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);

    // Grantee drops its request: pointer must land on 6
    step("drop.g5", 8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
    step("drop.r5", 8'h00, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
    step("drop.g6", 8'h60, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
    step("drop.r6", 8'h60, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0);

    // Timeout after 4 grant cycles, then done coinciding with timeout
    for (int c = 0; c < 4; c++)
      step($sformatf("tmo.h%0d", c), 8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    step("tmo.exp", 8'h04, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
    for (int c = 0; c < 4; c++)
      step($sformatf("coin.h%0d", c), 8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    step("coin.rel", 8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);

    // Async reset between edges while granted
    step("ar.g4", 8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    step("ar.h4", 8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.gv",  32'(bif.grant_valid),  32'd0);
    chk("ar.idx", 32'(bif.grant_idx),    32'd0);
    chk("ar.oh",  32'(bif.grant_onehot), 32'd0);
    chk("ar.exp", 32'(bif.expired),      32'd0);
    #1 rst_n = 1'b1;
    step("ar.g0", 8'h81, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
    step("ar.r0", 8'h81, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    step("end",   8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
